// File: rtl/lagarto_l15q_pkg.sv
// Shared types for the Lagarto -> OpenPiton L1.5 request queue.
// Contents:
//   RQTYPE_W, SIZE_W, OUTST_W   field widths of the L1.5 request and the credit counter
//   L15Q_ADDR_W, L15Q_DATA_W    default payload widths
//   l15q_entry_t                one queued request at the default widths
//   l15q_state_e                issue FSM states
package lagarto_l15q_pkg;

    localparam int RQTYPE_W    = 5;
    localparam int SIZE_W      = 3;
    localparam int OUTST_W     = 4;
    localparam int L15Q_ADDR_W = 40;
    localparam int L15Q_DATA_W = 64;

    typedef struct packed {
        logic [RQTYPE_W-1:0]    rqtype;
        logic                   nc;
        logic [SIZE_W-1:0]      size;
        logic [L15Q_ADDR_W-1:0] addr;
        logic [L15Q_DATA_W-1:0] data;
    } l15q_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } l15q_state_e;

endpackage

// File: rtl/lagarto_l15_req_queue_if.sv
// Bus bundle of the L1.5 request queue: core request side, L1.5 request
// side, return-completion strobe and status.
// Modports:
//   slave  - the queue itself (takes core requests, drives the L1.5 port)
//   master - the environment (core + L1.5) around the queue
interface lagarto_l15_req_queue_if
    import lagarto_l15q_pkg::*;
#(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64
);
    // core request side
    logic                req_valid_i;
    logic                req_ready_o;
    logic [RQTYPE_W-1:0] req_rqtype_i;
    logic                req_nc_i;
    logic [SIZE_W-1:0]   req_size_i;
    logic [ADDR_W-1:0]   req_addr_i;
    logic [DATA_W-1:0]   req_data_i;
    // L1.5 request side
    logic                l15_val_o;
    logic [RQTYPE_W-1:0] l15_rqtype_o;
    logic                l15_nc_o;
    logic [SIZE_W-1:0]   l15_size_o;
    logic [ADDR_W-1:0]   l15_address_o;
    logic [DATA_W-1:0]   l15_data_o;
    logic                l15_header_ack_i;
    // return completion and status
    logic                rtrn_done_i;
    logic [OUTST_W-1:0]  outstanding_o;
    logic                err_o;

    modport slave (
        input  req_valid_i, req_rqtype_i, req_nc_i, req_size_i, req_addr_i, req_data_i,
        output req_ready_o,
        output l15_val_o, l15_rqtype_o, l15_nc_o, l15_size_o, l15_address_o, l15_data_o,
        input  l15_header_ack_i,
        input  rtrn_done_i,
        output outstanding_o, err_o
    );

    modport master (
        output req_valid_i, req_rqtype_i, req_nc_i, req_size_i, req_addr_i, req_data_i,
        input  req_ready_o,
        input  l15_val_o, l15_rqtype_o, l15_nc_o, l15_size_o, l15_address_o, l15_data_o,
        output l15_header_ack_i,
        output rtrn_done_i,
        input  outstanding_o, err_o
    );

endinterface

// File: rtl/lagarto_l15q_fifo.sv
// Generic DEPTH-entry FIFO of request entries.
// Ports:
//   clk_i, reset_l     clock, async active-low reset (pointers/count only)
//   push_i, din_i      write an entry (ignored when full)
//   pop_i              drop the head entry (ignored when empty)
//   dout_o             head entry, valid while !empty_o
//   count_o            occupancy 0..DEPTH
//   full_o, empty_o    occupancy flags
module lagarto_l15q_fifo
    import lagarto_l15q_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = l15q_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_l,
    input  logic             push_i,
    input  entry_t           din_i,
    input  logic             pop_i,
    output entry_t           dout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    // Payload storage needs no reset; the count gates its validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/lagarto_l15_req_queue.sv
// Request buffer between the Lagarto memory-request path and the OpenPiton
// L1.5 request port. Requests are queued in a DEPTH-entry FIFO, presented
// one at a time and held until l15_header_ack_i, and the number of acked
// requests still waiting for their return is capped at MAX_OUTSTANDING.
// Ports:
//   clk_i, reset_l      clock, async active-low reset
//   bus (slave)         core request, L1.5 request, rtrn_done_i, outstanding_o, err_o
//   perf_issued_o       headers acked (wraps)           -- LAGARTO_L15Q_PERF_EN only
//   perf_stall_o        cycles blocked on credits (wraps) -- LAGARTO_L15Q_PERF_EN only
// Optional feature macro: LAGARTO_L15Q_PERF_EN.
// ADDR_W/DATA_W must match the parameters of the connected interface.
module lagarto_l15_req_queue
    import lagarto_l15q_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 40,
    parameter int DATA_W          = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_l,
    lagarto_l15_req_queue_if.slave  bus
`ifdef LAGARTO_L15Q_PERF_EN
    ,
    output logic [31:0]             perf_issued_o,
    output logic [31:0]             perf_stall_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Same layout as l15q_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [RQTYPE_W-1:0] rqtype;
        logic                nc;
        logic [SIZE_W-1:0]   size;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } entry_t;

    entry_t             din, head;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               full, empty;
    logic               push, pop, rtrn_ok, credit;
    logic [OUTST_W-1:0] outst, outst_nxt;
    logic               err;
    l15q_state_e        state, state_nxt;

    assign din = '{rqtype: bus.req_rqtype_i, nc: bus.req_nc_i, size: bus.req_size_i,
                   addr: bus.req_addr_i, data: bus.req_data_i};

    lagarto_l15q_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_l (reset_l),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Ready looks only at the registered count, so a same-cycle pop never
    // opens a full queue and there is no ready<-ack combinational path.
    assign bus.req_ready_o = ~full;
    assign push            = bus.req_valid_i & ~full;
    assign pop             = (state == ISSUE) & bus.l15_header_ack_i & ~empty;

    // A return with nothing in flight is an error and must not underflow.
    assign rtrn_ok   = bus.rtrn_done_i & (outst != '0);
    assign outst_nxt = outst + OUTST_W'(pop) - OUTST_W'(rtrn_ok);
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign credit    = (outst_nxt < OUTST_W'(MAX_OUTSTANDING));

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
            outst <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            outst <= outst_nxt;
            if (bus.rtrn_done_i && outst == '0) err <= 1'b1;
        end
    end

    // Deciding on next-cycle count/credit lets a push into an empty queue
    // show l15_val_o the following cycle, and a freed credit be used the
    // cycle after the return.
    always_comb begin
        state_nxt = state;
        case (state)
            ISSUE: begin
                if (bus.l15_header_ack_i)
                    state_nxt = (count_nxt != '0 && credit) ? ISSUE : IDLE;
            end
            default: begin
                if (count_nxt != '0 && credit) state_nxt = ISSUE;
            end
        endcase
    end

    assign bus.l15_val_o     = (state == ISSUE);
    assign bus.l15_rqtype_o  = head.rqtype;
    assign bus.l15_nc_o      = head.nc;
    assign bus.l15_size_o    = head.size;
    assign bus.l15_address_o = head.addr;
    assign bus.l15_data_o    = head.data;
    assign bus.outstanding_o = outst;
    assign bus.err_o         = err;

`ifdef LAGARTO_L15Q_PERF_EN
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            perf_issued_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (pop) perf_issued_o <= perf_issued_o + 32'd1;
            if (count != '0 && outst == OUTST_W'(MAX_OUTSTANDING))
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
